// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants, tag record and IEEE-754 single classifiers.
// Revision    : 1.0
// ============================================================================
package fpu_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          FLG_INV = 3;
    localparam int          FLG_DZ  = 2;
    localparam int          FLG_OVF = 1;
    localparam int          FLG_UNF = 0;
    localparam int          OWNER_W = 3;

    // One in-flight op; special ops carry their final result with them.
    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               special;
        logic [31:0]        sres;
        logic               inv;
        logic               dz;
    } tag_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, one-hot combinational grant.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gidx;
    logic [PW:0]   w_idx;
    logic          w_found;

    // Scan from the pointer upward, wrapping modulo N.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                gnt[w_idx[PW-1:0]] = 1'b1;
                w_found            = 1'b1;
                w_gidx             = w_idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_share_sched
// Description : Shares one pipelined FP32 divider among NREQ requesters.
// Revision    : 1.0
// ============================================================================
module fdiv_share_sched
    import fpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREQ    = 4,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [XLEN-1:0]      div_a,
    output logic [XLEN-1:0]      div_b,
    input  logic [XLEN-1:0]      div_result,
    input  logic                 div_ovf,
    input  logic                 div_unf,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [XLEN-1:0]      rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);

    logic [NREQ-1:0]    w_req;
    logic [NREQ-1:0]    w_gnt;
    logic               w_issue;
    logic [OWNER_W-1:0] w_owner;
    logic [XLEN-1:0]    w_a;
    logic [XLEN-1:0]    w_b;
    logic               w_inv;
    logic               w_dz;
    tag_t               w_new_tag;
    tag_t               w_ret;
    logic [3:0]         w_flags;

    logic [XLEN-1:0]    r_div_a;
    logic [XLEN-1:0]    r_div_b;
    tag_t               r_tag [LATENCY];
    logic [NREQ-1:0]    r_rsp_valid;
    logic [XLEN-1:0]    r_rsp_result;
    logic [3:0]         r_rsp_flags;

    // Requests are masked during reset so no grant is visible then.
    assign w_req = req_valid & {NREQ{~rst}};

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_issue   = |w_gnt;

    always_comb begin
        w_owner = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_owner = OWNER_W'(i);
                w_a     = req_a[i*XLEN +: XLEN];
                w_b     = req_b[i*XLEN +: XLEN];
            end
        end
    end

    // x/0 only counts as divide-by-zero for a finite non-zero dividend.
    assign w_inv = is_nan(w_a) || is_nan(w_b) ||
                   (is_zero(w_a) && is_zero(w_b)) ||
                   (is_inf(w_a) && is_inf(w_b));
    assign w_dz  = is_zero(w_b) && !is_zero(w_a) && !is_inf(w_a) && !is_nan(w_a);

    always_comb begin
        w_new_tag = '0;
        if (w_issue) begin
            w_new_tag.valid   = 1'b1;
            w_new_tag.owner   = w_owner;
            w_new_tag.special = w_inv || w_dz;
            w_new_tag.sres    = w_inv ? QNAN : {w_a[31] ^ w_b[31], 8'hFF, 23'd0};
            w_new_tag.inv     = w_inv;
            w_new_tag.dz      = w_dz && !w_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_a <= '0;
            r_div_b <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_div_a <= w_a;
                r_div_b <= w_b;
            end
            r_tag[0] <= w_new_tag;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_ret = r_tag[LATENCY-1];

    always_comb begin
        w_flags          = '0;
        w_flags[FLG_INV] = w_ret.inv;
        w_flags[FLG_DZ]  = w_ret.dz;
        w_flags[FLG_OVF] = !w_ret.special && div_ovf;
        w_flags[FLG_UNF] = !w_ret.special && div_unf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_valid[i] <= w_ret.valid && (w_ret.owner == OWNER_W'(i));
            end
            if (w_ret.valid) begin
                r_rsp_result <= w_ret.special ? w_ret.sres : div_result;
                r_rsp_flags  <= w_flags;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            busy = busy | r_tag[s].valid;
        end
    end

    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule
`default_nettype wire
